ram_responder: RTL and testbench

Byte-addressable synchronous RAM that serves the memory side of the CPU's MAR/MDR handshake. It accepts a request strobed by the control unit, performs a byte, halfword or word read or write after a configurable latency, and raises MOC (memory operation complete) until the request is withdrawn. It sits between the MAR/MDR registers and the datapath's B-input mux (RAM leg), answering the MOC input the control unit waits on.

---
 rtl/ram_responder.sv | 160 ++++++++++++++++
 tb/tb_ram_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// ram_responder: byte-addressable big-endian RAM answering the CPU's
// MAR/MDR handshake (MFA in, MOC out) after a fixed access latency.
// Optional feature macro: RAM_ALIGN_CHECK_EN. When it is defined,
// misaligned halfword/word requests complete the handshake without
// touching memory or data_out and raise err. When it is undefined,
// addresses are silently aligned and err is tied to 0.
module ram_responder #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        MFA,
  input  logic        R_W,
  input  logic [1:0]  DT,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        MOC,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t state, nextState;

  logic [3:0]        count;
  logic [ADDR_W-1:0] addrQ;
  logic [1:0]        dtQ;
  logic              readQ;
  logic [31:0]       dataQ;

  logic              accept;
  logic              doAccess;
  logic              mocNext;
  logic              accessOk;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0]       readWord;

  logic [7:0] mem [2**ADDR_W];

  // Address bits above the implemented range wrap and are intentionally dropped
  logic unusedAddrBits;
  assign unusedAddrBits = ^addr[31:ADDR_W];

  // FSM state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state logic: accept in IDLE, count down in BUSY, wait for MFA low in ACK
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (MFA) nextState = BUSY;
      BUSY:    if (count == 4'd1) nextState = ACK;
      ACK:     if (!MFA) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // FSM outputs: accept strobe, access strobe and the next value of MOC
  always_comb begin
    accept   = (state == IDLE) && MFA;
    doAccess = (state == BUSY) && (count == 4'd1);
    mocNext  = (nextState == ACK);
  end

  // Effective byte addresses of the access: aligned base plus successors
  always_comb begin
    case (dtQ)
      2'b00:   a0 = addrQ;
      2'b01:   a0 = {addrQ[ADDR_W-1:1], 1'b0};
      default: a0 = {addrQ[ADDR_W-1:2], 2'b00};
    endcase
    a1 = a0 + ADDR_W'(1);
    a2 = a0 + ADDR_W'(2);
    a3 = a0 + ADDR_W'(3);
  end

`ifdef RAM_ALIGN_CHECK_EN
  // A misaligned halfword or word request is completed without any access
  always_comb begin
    accessOk = 1'b1;
    if (dtQ == 2'b01 && addrQ[0])          accessOk = 1'b0;
    if (dtQ[1] && (addrQ[1:0] != 2'b00))   accessOk = 1'b0;
  end
`else
  assign accessOk = 1'b1;
`endif

  // Big-endian read assembly, zero-extended for byte and halfword
  always_comb begin
    readWord = 32'd0;
    case (dtQ)
      2'b00:   readWord = {24'd0, mem[a0]};
      2'b01:   readWord = {16'd0, mem[a0], mem[a1]};
      default: readWord = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  // Request capture, latency counter and registered outputs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count    <= 4'd0;
      addrQ    <= '0;
      dtQ      <= 2'b00;
      readQ    <= 1'b0;
      dataQ    <= 32'd0;
      data_out <= 32'd0;
      MOC      <= 1'b0;
    end else begin
      if (accept) begin
        count <= 4'(LATENCY);
        addrQ <= addr[ADDR_W-1:0];
        dtQ   <= DT;
        readQ <= R_W;
        dataQ <= data_in;
      end else if (state == BUSY) begin
        count <= count - 4'd1;
      end
      if (doAccess && readQ && accessOk) data_out <= readWord;
      MOC <= mocNext;
    end
  end

`ifdef RAM_ALIGN_CHECK_EN
  // Error flag is set at the access edge and cleared on return to IDLE
  logic errQ;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                   errQ <= 1'b0;
    else if (doAccess)          errQ <= !accessOk;
    else if (nextState != ACK)  errQ <= 1'b0;
  end
  assign err = errQ;
`else
  assign err = 1'b0;
`endif

  // Memory write on the access edge; contents are not affected by reset
  always_ff @(posedge clk) begin
    if (clr && doAccess && !readQ && accessOk) begin
      case (dtQ)
        2'b00: mem[a0] <= dataQ[7:0];
        2'b01: begin
          mem[a0] <= dataQ[15:8];
          mem[a1] <= dataQ[7:0];
        end
        default: begin
          mem[a0] <= dataQ[31:24];
          mem[a1] <= dataQ[23:16];
          mem[a2] <= dataQ[15:8];
          mem[a3] <= dataQ[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder (ADDR_W=9, LATENCY=3).
// Misaligned-write expectations follow RAM_ALIGN_CHECK_EN.
module tb_ram_responder;

  logic        clk;
  logic        clr;
  logic        MFA;
  logic        R_W;
  logic [1:0]  DT;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        MOC;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] held;
  logic        errSeen;

  ram_responder #(.ADDR_W(9), .LATENCY(3)) dut (
    .clk      (clk),
    .clr      (clr),
    .MFA      (MFA),
    .R_W      (R_W),
    .DT       (DT),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .MOC      (MOC),
    .err      (err)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the values differ
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One full handshake: raise MFA, wait (bounded) for MOC, sample err, drop MFA
  task automatic applyStimulus(input logic rw, input logic [1:0] dt, input logic [31:0] a,
                               input logic [31:0] d, output logic errOut);
    int n;
    @(negedge clk);
    MFA = 1'b1; R_W = rw; DT = dt; addr = a; data_in = d;
    n = 0;
    while (!MOC && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("handshake MOC", {31'd0, MOC}, 32'd1);
    errOut = err;
    MFA = 1'b0;
    @(negedge clk);
    checkOutput("MOC release", {31'd0, MOC}, 32'd0);
  endtask

  initial begin
    clr = 1'b0; MFA = 1'b0; R_W = 1'b1; DT = 2'b10; addr = 32'd0; data_in = 32'd0;
    #12;
    checkOutput("reset MOC", {31'd0, MOC}, 32'd0);
    checkOutput("reset data_out", data_out, 32'd0);
    checkOutput("reset err", {31'd0, err}, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // Word write then word/byte/halfword reads
    applyStimulus(1'b0, 2'b10, 32'h20, 32'hDEADBEEF, errSeen);
    checkOutput("write leaves data_out", data_out, 32'd0);
    applyStimulus(1'b1, 2'b10, 32'h20, 32'h0, errSeen);
    checkOutput("word read 0x20", data_out, 32'hDEADBEEF);
    checkOutput("aligned err", {31'd0, errSeen}, 32'd0);
    applyStimulus(1'b1, 2'b00, 32'h20, 32'h0, errSeen);
    checkOutput("byte read 0x20", data_out, 32'h000000DE);
    applyStimulus(1'b1, 2'b00, 32'h23, 32'h0, errSeen);
    checkOutput("byte read 0x23", data_out, 32'h000000EF);
    applyStimulus(1'b1, 2'b01, 32'h22, 32'h0, errSeen);
    checkOutput("half read 0x22", data_out, 32'h0000BEEF);
    applyStimulus(1'b1, 2'b11, 32'h20, 32'h0, errSeen);
    checkOutput("DT=11 read 0x20", data_out, 32'hDEADBEEF);

    // Halfword write keeps the lower half of the word
    applyStimulus(1'b0, 2'b10, 32'h40, 32'h55667788, errSeen);
    applyStimulus(1'b0, 2'b01, 32'h40, 32'h1234ABCD, errSeen);
    applyStimulus(1'b1, 2'b10, 32'h40, 32'h0, errSeen);
    checkOutput("half write 0x40", data_out, 32'hABCD7788);

    // Byte write touches exactly one byte
    applyStimulus(1'b0, 2'b00, 32'h42, 32'hFFFFFF99, errSeen);
    applyStimulus(1'b1, 2'b10, 32'h40, 32'h0, errSeen);
    checkOutput("byte write 0x42", data_out, 32'hABCD9988);

    // Address wrap at 2^9 bytes
    applyStimulus(1'b0, 2'b10, 32'h0000_0204, 32'h11223344, errSeen);
    applyStimulus(1'b1, 2'b10, 32'h004, 32'h0, errSeen);
    checkOutput("wrap read 0x004", data_out, 32'h11223344);

    // Misaligned word write to 0x22
    applyStimulus(1'b0, 2'b10, 32'h22, 32'hCAFEF00D, errSeen);
`ifdef RAM_ALIGN_CHECK_EN
    checkOutput("misaligned err", {31'd0, errSeen}, 32'd1);
    checkOutput("err clears", {31'd0, err}, 32'd0);
    applyStimulus(1'b1, 2'b10, 32'h20, 32'h0, errSeen);
    checkOutput("misaligned no write", data_out, 32'hDEADBEEF);
`else
    checkOutput("misaligned err", {31'd0, errSeen}, 32'd0);
    applyStimulus(1'b1, 2'b10, 32'h20, 32'h0, errSeen);
    checkOutput("misaligned lands 0x20", data_out, 32'hCAFEF00D);
`endif

    // Reset in the middle of a write aborts it
    applyStimulus(1'b0, 2'b10, 32'h10, 32'hA5A5A5A5, errSeen);
    applyStimulus(1'b1, 2'b10, 32'h10, 32'h0, errSeen);
    checkOutput("prep read 0x10", data_out, 32'hA5A5A5A5);
    @(negedge clk);
    MFA = 1'b1; R_W = 1'b0; DT = 2'b10; addr = 32'h10; data_in = 32'hFFFFFFFF;
    @(negedge clk);
    clr = 1'b0; MFA = 1'b0;
    #1;
    checkOutput("abort MOC", {31'd0, MOC}, 32'd0);
    checkOutput("abort data_out", data_out, 32'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort idle MOC", {31'd0, MOC}, 32'd0);
    applyStimulus(1'b1, 2'b10, 32'h10, 32'h0, errSeen);
    checkOutput("abort no write", data_out, 32'hA5A5A5A5);

    // Latency and hold: MOC rises after the third edge, holds, falls one edge after MFA drops
    @(negedge clk);
    MFA = 1'b1; R_W = 1'b1; DT = 2'b10; addr = 32'h20;
    @(negedge clk); checkOutput("lat edge N", {31'd0, MOC}, 32'd0);
    addr = 32'h40;
    @(negedge clk); checkOutput("lat edge N+1", {31'd0, MOC}, 32'd0);
    @(negedge clk); checkOutput("lat edge N+2", {31'd0, MOC}, 32'd0);
    @(negedge clk); checkOutput("lat edge N+3", {31'd0, MOC}, 32'd1);
    held = data_out;
`ifdef RAM_ALIGN_CHECK_EN
    checkOutput("lat read data", held, 32'hDEADBEEF);
`else
    checkOutput("lat read data", held, 32'hCAFEF00D);
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("MOC hold", {31'd0, MOC}, 32'd1);
    end
    MFA = 1'b0;
    @(negedge clk); checkOutput("MOC drop", {31'd0, MOC}, 32'd0);

    // MFA withdrawn during BUSY: access still completes, ACK lasts one edge
    @(negedge clk);
    MFA = 1'b1; R_W = 1'b1; DT = 2'b00; addr = 32'h43;
    @(negedge clk);
    MFA = 1'b0;
    @(negedge clk);
    @(negedge clk); checkOutput("short MFA pre", {31'd0, MOC}, 32'd0);
    @(negedge clk); checkOutput("short MFA ack", {31'd0, MOC}, 32'd1);
    checkOutput("short MFA data", data_out, 32'h00000088);
    @(negedge clk); checkOutput("short MFA exit", {31'd0, MOC}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
